// File: rtl/proc_mc_if.sv
// Memory-side bus of proc_mc: one outstanding request at a time, completed by mem_ack.
// The core drives requests through the master modport; the memory controller uses slave.
interface proc_mc_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic [31:0] mem_wr_data;
   logic        mem_wr_req;
   logic        mem_rd_req;
   logic        mem_ack;
   logic        mem_busy;

   modport master (
      output mem_addr, mem_wr_data, mem_wr_req, mem_rd_req,
      input  mem_rd_data, mem_ack, mem_busy
   );

   modport slave (
      input  mem_addr, mem_wr_data, mem_wr_req, mem_rd_req,
      output mem_rd_data, mem_ack, mem_busy
   );
endinterface

// File: rtl/proc_mc.sv
// Multi-cycle RV32I+MUL core with a shared instruction/data memory port and MMIO output/halt stores.
// Every output is taken straight from a register.
module proc_mc #(
   parameter int          NUM_REGS   = 32,
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter logic [31:0] OUT_ADDR   = 32'd1000,
   parameter logic [31:0] HALT_ADDR  = 32'd1004,
   parameter logic [31:0] OUTFL_ADDR = 32'd1008
) (
   input  logic        clk,
   input  logic        rst,
   proc_mc_if.master   mem,
   output logic [31:0] out_o,
   output logic        outen_o,
   output logic        outflen_o,
   output logic [31:0] x1_o,
   output logic [31:0] pc_o,
   output logic [2:0]  state_o,
   output logic        halt_o
);

   localparam int         IDXW       = (NUM_REGS == 16) ? 4 : 5;
   localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);

   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      FWAIT  = 3'd1,
      EXEC   = 3'd2,
      MWAIT  = 3'd3,
      HALTED = 3'd4
   } stateT;

   stateT       state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] outData_q, outData_d;
   logic        outEn_q, outEn_d;
   logic        outFlEn_q, outFlEn_d;
   logic [31:0] memAddr_q, memAddr_d;
   logic [31:0] memWrData_q, memWrData_d;
   logic        memWrReq_q, memWrReq_d;
   logic        memRdReq_q, memRdReq_d;
   logic        halt_q, halt_d;
   logic [31:0] regs_q [NUM_REGS];

   logic        regWe;
   logic [31:0] regWdata;

   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2, shamt;
   logic [2:0]  f3;
   logic [31:0] immI, immS, immB, immU, immJ;
   logic [31:0] rs1Val, rs2Val, opB, aluRes, mulRes;
   logic [31:0] pcPlus4, brTarget, jalTarget, jalrTarget, ea;
   logic        brTaken, illegal, badIdx, useRd, useRs1, useRs2;

   assign opcode = instr_q[6:0];
   assign rd     = instr_q[11:7];
   assign f3     = instr_q[14:12];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign f7     = instr_q[31:25];

   assign immI = {{20{instr_q[31]}}, instr_q[31:20]};
   assign immS = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign immB = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign immU = {instr_q[31:12], 12'b0};
   assign immJ = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

   // Register reads; indices beyond the implemented file read as zero (the instruction halts anyway).
   always_comb begin
      rs1Val = '0;
      rs2Val = '0;
      if (rs1 != 5'd0 && {1'b0, rs1} < NUM_REGS_L) rs1Val = regs_q[rs1[IDXW-1:0]];
      if (rs2 != 5'd0 && {1'b0, rs2} < NUM_REGS_L) rs2Val = regs_q[rs2[IDXW-1:0]];
   end

   // Legality and register-field usage per opcode, so only fields the format really uses are range-checked.
   always_comb begin
      illegal = 1'b0;
      useRd   = 1'b0;
      useRs1  = 1'b0;
      useRs2  = 1'b0;
      case (opcode)
         OPC_OPIMM: begin
            useRd   = 1'b1;
            useRs1  = 1'b1;
            illegal = (f3 == 3'b001 && f7 != 7'h00) ||
                      (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
         end
         OPC_OP: begin
            useRd   = 1'b1;
            useRs1  = 1'b1;
            useRs2  = 1'b1;
            illegal = !((f7 == 7'h00) ||
                        (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) ||
                        (f7 == 7'h01 && f3 == 3'b000));
         end
         OPC_LUI, OPC_AUIPC, OPC_JAL: useRd = 1'b1;
         OPC_JALR: begin
            useRd   = 1'b1;
            useRs1  = 1'b1;
            illegal = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            useRs1  = 1'b1;
            useRs2  = 1'b1;
            illegal = (f3 == 3'b010 || f3 == 3'b011);
         end
         OPC_LOAD: begin
            useRd   = 1'b1;
            useRs1  = 1'b1;
            illegal = (f3 != 3'b010);
         end
         OPC_STORE: begin
            useRs1  = 1'b1;
            useRs2  = 1'b1;
            illegal = (f3 != 3'b010);
         end
         default: illegal = 1'b1;
      endcase
      badIdx = (useRd  && {1'b0, rd}  >= NUM_REGS_L) ||
               (useRs1 && {1'b0, rs1} >= NUM_REGS_L) ||
               (useRs2 && {1'b0, rs2} >= NUM_REGS_L);
   end

   assign opB    = (opcode == OPC_OP) ? rs2Val : immI;
   assign shamt  = opB[4:0];
   assign mulRes = rs1Val * opB;

   // Shared ALU for OP and OP-IMM; f7 doubles as the upper immediate bits for the shift-immediates.
   always_comb begin
      aluRes = '0;
      case (f3)
         3'b000: begin
            if (opcode == OPC_OP && f7 == 7'h20)      aluRes = rs1Val - opB;
            else if (opcode == OPC_OP && f7 == 7'h01) aluRes = mulRes;
            else                                      aluRes = rs1Val + opB;
         end
         3'b001: aluRes = rs1Val << shamt;
         3'b010: aluRes = {31'b0, $signed(rs1Val) < $signed(opB)};
         3'b011: aluRes = {31'b0, rs1Val < opB};
         3'b100: aluRes = rs1Val ^ opB;
         3'b101: aluRes = f7[5] ? 32'($signed(rs1Val) >>> shamt) : (rs1Val >> shamt);
         3'b110: aluRes = rs1Val | opB;
         3'b111: aluRes = rs1Val & opB;
         default: aluRes = '0;
      endcase
   end

   always_comb begin
      brTaken = 1'b0;
      case (f3)
         3'b000: brTaken = (rs1Val == rs2Val);
         3'b001: brTaken = (rs1Val != rs2Val);
         3'b100: brTaken = ($signed(rs1Val) <  $signed(rs2Val));
         3'b101: brTaken = ($signed(rs1Val) >= $signed(rs2Val));
         3'b110: brTaken = (rs1Val <  rs2Val);
         3'b111: brTaken = (rs1Val >= rs2Val);
         default: brTaken = 1'b0;
      endcase
   end

   assign pcPlus4    = pc_q + 32'd4;
   assign brTarget   = brTaken ? (pc_q + immB) : pcPlus4;
   assign jalTarget  = pc_q + immJ;
   assign jalrTarget = (rs1Val + immI) & ~32'd1;
   assign ea         = rs1Val + ((opcode == OPC_STORE) ? immS : immI);

   // Next-state logic; request/pulse outputs default low so each lasts exactly one cycle.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      outData_d   = outData_q;
      outEn_d     = 1'b0;
      outFlEn_d   = 1'b0;
      memAddr_d   = memAddr_q;
      memWrData_d = memWrData_q;
      memWrReq_d  = 1'b0;
      memRdReq_d  = 1'b0;
      halt_d      = halt_q;
      regWe       = 1'b0;
      regWdata    = '0;
      case (state_q)
         FETCH: begin
            if (!mem.mem_busy) begin
               memRdReq_d = 1'b1;
               memAddr_d  = pc_q;
               state_d    = FWAIT;
            end
         end
         FWAIT: begin
            if (mem.mem_ack) begin
               instr_d = mem.mem_rd_data;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (illegal || badIdx) begin
               state_d = HALTED;
               halt_d  = 1'b1;
            end else begin
               case (opcode)
                  OPC_OPIMM, OPC_OP, OPC_LUI, OPC_AUIPC: begin
                     regWe = 1'b1;
                     if (opcode == OPC_LUI)        regWdata = immU;
                     else if (opcode == OPC_AUIPC) regWdata = pc_q + immU;
                     else                          regWdata = aluRes;
                     pc_d    = pcPlus4;
                     state_d = FETCH;
                  end
                  OPC_BRANCH: begin
                     if (brTarget[1:0] != 2'b00) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                     end else begin
                        pc_d    = brTarget;
                        state_d = FETCH;
                     end
                  end
                  OPC_JAL, OPC_JALR: begin
                     if ((opcode == OPC_JAL ? jalTarget[1:0] : jalrTarget[1:0]) != 2'b00) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                     end else begin
                        regWe    = 1'b1;
                        regWdata = pcPlus4;
                        pc_d     = (opcode == OPC_JAL) ? jalTarget : jalrTarget;
                        state_d  = FETCH;
                     end
                  end
                  OPC_STORE: begin
                     if (ea == OUT_ADDR || ea == OUTFL_ADDR) begin
                        outData_d = rs2Val;
                        outEn_d   = (ea == OUT_ADDR);
                        outFlEn_d = (ea == OUTFL_ADDR);
                        pc_d      = pcPlus4;
                        state_d   = FETCH;
                     end else if (ea == HALT_ADDR) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                     end else if (!mem.mem_busy) begin
                        memWrReq_d  = 1'b1;
                        memAddr_d   = ea;
                        memWrData_d = rs2Val;
                        state_d     = MWAIT;
                     end
                  end
                  OPC_LOAD: begin
                     if (!mem.mem_busy) begin
                        memRdReq_d = 1'b1;
                        memAddr_d  = ea;
                        state_d    = MWAIT;
                     end
                  end
                  default: begin
                     state_d = HALTED;
                     halt_d  = 1'b1;
                  end
               endcase
            end
         end
         MWAIT: begin
            if (mem.mem_ack) begin
               if (opcode == OPC_LOAD) begin
                  regWe    = 1'b1;
                  regWdata = mem.mem_rd_data;
               end
               pc_d    = pcPlus4;
               state_d = FETCH;
            end
         end
         HALTED: halt_d = 1'b1;
         default: begin
            state_d = HALTED;
            halt_d  = 1'b1;
         end
      endcase
   end

   // Control and output registers; reset wins over any same-cycle ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         outData_q   <= '0;
         outEn_q     <= 1'b0;
         outFlEn_q   <= 1'b0;
         memAddr_q   <= '0;
         memWrData_q <= '0;
         memWrReq_q  <= 1'b0;
         memRdReq_q  <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         outData_q   <= outData_d;
         outEn_q     <= outEn_d;
         outFlEn_q   <= outFlEn_d;
         memAddr_q   <= memAddr_d;
         memWrData_q <= memWrData_d;
         memWrReq_q  <= memWrReq_d;
         memRdReq_q  <= memRdReq_d;
         halt_q      <= halt_d;
      end
   end

   // Register file; x0 is never written so it always reads back as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (regWe && rd != 5'd0) begin
         regs_q[rd[IDXW-1:0]] <= regWdata;
      end
   end

   assign mem.mem_addr    = memAddr_q;
   assign mem.mem_wr_data = memWrData_q;
   assign mem.mem_wr_req  = memWrReq_q;
   assign mem.mem_rd_req  = memRdReq_q;

   assign out_o     = outData_q;
   assign outen_o   = outEn_q;
   assign outflen_o = outFlEn_q;
   assign x1_o      = regs_q[1];
   assign pc_o      = pc_q;
   assign state_o   = state_q;
   assign halt_o    = halt_q;

endmodule

// File: tb/tb_proc_mc.sv
// Directed-program bench for proc_mc: a scoreboard matches every MMIO pulse and traced fetch
// against expectations queued when each program is built.
module tb_proc_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busyIn = 1'b0;
   logic        loadReq = 1'b0;
   logic [31:0] out_o, x1_o, pc_o;
   logic        outen_o, outflen_o, halt_o;
   logic [2:0]  state_o;

   logic [31:0] memArr [256];
   logic [31:0] progQ [$];
   logic [31:0] expOut [$];
   bit          expFl [$];
   logic [31:0] expFetch [$];
   bit          fetchCheckEn = 1'b0;
   int          outRd = 0;
   int          fetchRd = 0;
   int          wrCount = 0;
   int          compareCount = 0;
   int          failCount = 0;

   proc_mc_if bus ();

   proc_mc #(.NUM_REGS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem       (bus),
      .out_o     (out_o),
      .outen_o   (outen_o),
      .outflen_o (outflen_o),
      .x1_o      (x1_o),
      .pc_o      (pc_o),
      .state_o   (state_o),
      .halt_o    (halt_o)
   );

   always #5 clk = ~clk;

   // Memory acknowledges in the same cycle the request is visible (1-cycle ack).
   assign bus.mem_busy    = busyIn;
   assign bus.mem_ack     = bus.mem_rd_req | bus.mem_wr_req;
   assign bus.mem_rd_data = memArr[bus.mem_addr[9:2]];

   always @(posedge clk) begin
      if (loadReq) begin
         for (int i = 0; i < 256; i++) memArr[i] <= (i < progQ.size()) ? progQ[i] : 32'h0;
      end else if (bus.mem_wr_req) begin
         memArr[bus.mem_addr[9:2]] <= bus.mem_wr_data;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: every output pulse and (when enabled) every fetch is matched in order.
   always @(negedge clk) begin
      if (bus.mem_wr_req) wrCount++;
      if (outen_o || outflen_o) begin
         if (outRd >= expOut.size()) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL unexpectedOutPulse: got out=0x%08h outen=%0b outflen=%0b, expected no pulse",
                     out_o, outen_o, outflen_o);
         end else begin
            checkOutput("outData", out_o, expOut[outRd]);
            checkOutput("outKind", {30'b0, outen_o, outflen_o}, {30'b0, !expFl[outRd], expFl[outRd]});
            outRd++;
         end
      end
      if (fetchCheckEn && bus.mem_rd_req) begin
         if (fetchRd >= expFetch.size()) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL unexpectedFetch: got addr=0x%08h, expected no fetch", bus.mem_addr);
         end else begin
            checkOutput("fetchAddr", bus.mem_addr, expFetch[fetchRd]);
            fetchRd++;
         end
      end
   end

   function automatic logic [31:0] encR(input logic [31:0] f7, rs2, rs1, f3, rd, op);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] encI(input logic [31:0] imm, rs1, f3, rd, op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] encS(input logic [31:0] imm, rs2, rs1, f3, op);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] encB(input logic [31:0] imm, rs2, rs1, f3, op);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], op[6:0]};
   endfunction
   function automatic logic [31:0] encU(input logic [31:0] imm, rd, op);
      return {imm[19:0], rd[4:0], op[6:0]};
   endfunction
   function automatic logic [31:0] encJ(input logic [31:0] imm, rd, op);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] addi(input logic [31:0] rd, rs1, imm);
      return encI(imm, rs1, 0, rd, 32'h13);
   endfunction
   function automatic logic [31:0] swOut(input logic [31:0] rs2, addr);
      return encS(addr, rs2, 0, 2, 32'h23);
   endfunction

   // Loads progQ into memory while the core is held in reset; returns at a negedge with rst still high.
   task automatic applyStimulus();
      rst = 1'b1;
      busyIn = 1'b0;
      loadReq = 1'b1;
      @(posedge clk);
      #1 loadReq = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic waitHalt(input string name, input int budget);
      int n = 0;
      while (!halt_o && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_halt"}, {31'b0, halt_o}, 32'd1);
      checkOutput({name, "_haltState"}, {29'b0, state_o}, 32'd4);
   endtask

   task automatic waitExec(input logic [2:0] st, input logic [31:0] pcv, input int budget);
      int n = 0;
      while (!(state_o == st && pc_o == pcv) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("waitStatePc", {state_o, pc_o[28:0]}, {st, pcv[28:0]});
   endtask

   task automatic loadProgA();
      progQ.delete();
      progQ.push_back(addi(1, 0, 5));
      progQ.push_back(addi(1, 1, -7));
      progQ.push_back(swOut(0, 1004));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int wrBase;

      // ---- Program A: reset values, ADDI timing and sign handling ----
      loadProgA();
      applyStimulus();
      checkOutput("resetPc", pc_o, 32'd0);
      checkOutput("resetCtrl", {26'b0, state_o, halt_o, outen_o, outflen_o},  32'd0);
      checkOutput("resetMem", {30'b0, bus.mem_rd_req, bus.mem_wr_req}, 32'd0);
      checkOutput("resetAddr", bus.mem_addr, 32'd0);
      checkOutput("resetOut", out_o, 32'd0);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("addiPc6", pc_o, 32'd8);
      checkOutput("addiX1", x1_o, 32'hFFFF_FFFE);
      waitHalt("progA", 100);
      checkOutput("progAHaltPc", pc_o, 32'd8);

      // ---- Program B: MUL to OUT, shifts, compares, SUB, LUI/AUIPC/XOR, float output ----
      progQ.delete();
      progQ.push_back(addi(1, 0, 3));
      progQ.push_back(addi(2, 0, 4));
      progQ.push_back(encR(1, 2, 1, 0, 3, 32'h33));
      progQ.push_back(swOut(3, 1000));
      progQ.push_back(addi(4, 0, -16));
      progQ.push_back(encI(32'h402, 4, 5, 5, 32'h13));
      progQ.push_back(swOut(5, 1000));
      progQ.push_back(encI(28, 4, 5, 5, 32'h13));
      progQ.push_back(swOut(5, 1008));
      progQ.push_back(encR(0, 4, 1, 3, 6, 32'h33));
      progQ.push_back(encR(0, 4, 1, 2, 7, 32'h33));
      progQ.push_back(swOut(6, 1000));
      progQ.push_back(swOut(7, 1000));
      progQ.push_back(encR(32'h20, 1, 6, 0, 8, 32'h33));
      progQ.push_back(swOut(8, 1000));
      progQ.push_back(encU(32'h12345, 9, 32'h37));
      progQ.push_back(encU(32'h1, 10, 32'h17));
      progQ.push_back(encR(0, 10, 9, 4, 11, 32'h33));
      progQ.push_back(swOut(11, 1000));
      progQ.push_back(swOut(0, 1004));
      expOut.push_back(32'd12);         expFl.push_back(1'b0);
      expOut.push_back(32'hFFFF_FFFC);  expFl.push_back(1'b0);
      expOut.push_back(32'h0000_000F);  expFl.push_back(1'b1);
      expOut.push_back(32'd1);          expFl.push_back(1'b0);
      expOut.push_back(32'd0);          expFl.push_back(1'b0);
      expOut.push_back(32'hFFFF_FFFE);  expFl.push_back(1'b0);
      expOut.push_back(32'h1234_4040);  expFl.push_back(1'b0);
      applyStimulus();
      wrBase = wrCount;
      rst = 1'b0;
      waitHalt("progB", 400);
      checkOutput("progBOutCount", outRd, expOut.size());
      checkOutput("progBNoWrReq", wrCount - wrBase, 32'd0);

      // ---- Program C: BNE taken/not taken, JAL, JALR, misaligned branch target ----
      progQ.delete();
      progQ.push_back(addi(1, 0, 1));
      progQ.push_back(addi(2, 0, 3));
      progQ.push_back(swOut(1, 1000));
      progQ.push_back(addi(1, 1, 1));
      progQ.push_back(encB(-8, 2, 1, 1, 32'h63));
      progQ.push_back(encJ(12, 5, 32'h6F));
      progQ.push_back(swOut(0, 1004));
      progQ.push_back(swOut(0, 1004));
      progQ.push_back(swOut(5, 1000));
      progQ.push_back(encI(17, 5, 0, 6, 32'h67));
      progQ.push_back(swOut(6, 1000));
      progQ.push_back(encB(6, 0, 0, 0, 32'h63));
      foreach (progQ[i]) if (i < 0) progQ.delete(i);
      expOut.push_back(32'd1);   expFl.push_back(1'b0);
      expOut.push_back(32'd2);   expFl.push_back(1'b0);
      expOut.push_back(32'd24);  expFl.push_back(1'b0);
      expOut.push_back(32'd40);  expFl.push_back(1'b0);
      foreach (progQ[i]) begin
         if (i == 0) begin
            expFetch.push_back(0);  expFetch.push_back(4);  expFetch.push_back(8);
            expFetch.push_back(12); expFetch.push_back(16); expFetch.push_back(8);
            expFetch.push_back(12); expFetch.push_back(16); expFetch.push_back(20);
            expFetch.push_back(32); expFetch.push_back(36); expFetch.push_back(40);
            expFetch.push_back(44);
         end
      end
      applyStimulus();
      fetchCheckEn = 1'b1;
      rst = 1'b0;
      waitHalt("progC", 400);
      fetchCheckEn = 1'b0;
      checkOutput("progCMisalignPc", pc_o, 32'd44);
      checkOutput("progCOutCount", outRd, expOut.size());
      checkOutput("progCFetchCount", fetchRd, expFetch.size());

      // ---- Program D: SW stalled by mem_busy, then LW read-back ----
      progQ.delete();
      progQ.push_back(addi(5, 0, 32'h123));
      progQ.push_back(encS(64, 5, 0, 2, 32'h23));
      progQ.push_back(encI(64, 0, 2, 6, 32'h03));
      progQ.push_back(swOut(6, 1000));
      progQ.push_back(swOut(0, 1004));
      expOut.push_back(32'h123); expFl.push_back(1'b0);
      applyStimulus();
      wrBase = wrCount;
      rst = 1'b0;
      waitExec(3'd2, 32'd4, 100);
      busyIn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("busyHoldState", {29'b0, state_o}, 32'd2);
      checkOutput("busyNoWrReq", wrCount - wrBase, 32'd0);
      busyIn = 1'b0;
      @(negedge clk);
      checkOutput("swReqPulse", {31'b0, bus.mem_wr_req}, 32'd1);
      checkOutput("swReqAddr", bus.mem_addr, 32'd64);
      checkOutput("swReqData", bus.mem_wr_data, 32'h123);
      waitHalt("progD", 200);
      checkOutput("progDWrCount", wrCount - wrBase, 32'd1);
      checkOutput("progDOutCount", outRd, expOut.size());

      // ---- Reset arriving together with mem_ack in FWAIT ----
      loadProgA();
      applyStimulus();
      rst = 1'b0;
      waitExec(3'd1, 32'd4, 100);
      checkOutput("fwaitAckSeen", {31'b0, bus.mem_ack}, 32'd1);
      checkOutput("fwaitX1Before", x1_o, 32'd5);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rstFwaitState", {29'b0, state_o}, 32'd0);
      checkOutput("rstFwaitPc", pc_o, 32'd0);
      checkOutput("rstFwaitX1", x1_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstRefetchReq", {31'b0, bus.mem_rd_req}, 32'd1);
      checkOutput("rstRefetchAddr", bus.mem_addr, 32'd0);
      waitHalt("progG", 100);
      checkOutput("progGX1", x1_o, 32'hFFFF_FFFE);

      // ---- Register index beyond NUM_REGS=16 ----
      progQ.delete();
      progQ.push_back(addi(1, 0, 9));
      progQ.push_back(addi(20, 0, 1));
      progQ.push_back(addi(1, 0, 1));
      applyStimulus();
      rst = 1'b0;
      waitHalt("badIdx", 100);
      checkOutput("badIdxPc", pc_o, 32'd4);
      checkOutput("badIdxX1", x1_o, 32'd9);

      // ---- Illegal opcode 0x7F ----
      progQ.delete();
      progQ.push_back(addi(1, 0, 7));
      progQ.push_back(32'h0000_007F);
      progQ.push_back(addi(1, 0, 1));
      applyStimulus();
      rst = 1'b0;
      waitHalt("illegal", 100);
      repeat (5) @(negedge clk);
      checkOutput("illegalPcFrozen", pc_o, 32'd4);
      checkOutput("illegalX1", x1_o, 32'd7);
      checkOutput("illegalNoReq", {30'b0, bus.mem_rd_req, bus.mem_wr_req}, 32'd0);
      checkOutput("finalOutCount", outRd, expOut.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
